// File: rtl/rdecouple.sv
// Backward-path decoupler: registered din_ready with a small skid FIFO behind it.
// Define RDECOUPLE_BYPASS_EN to add the zero-latency empty-buffer path from din to dout.
module rdecouple #(
    parameter int DEPTH = 2,
    parameter int DIN   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DIN-1:0] din_data,
    input  logic           din_valid,
    output logic           din_ready,
    output logic [DIN-1:0] dout_data,
    output logic           dout_valid,
    input  logic           dout_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DIN-1:0] mem [DEPTH];
    logic [PW-1:0]  w_ptr;
    logic [PW-1:0]  r_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           empty;
    logic           push_in;
    logic           fifo_wr;
    logic           fifo_rd;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty   = (count == '0);
        push_in = din_valid & din_ready;
        fifo_rd = ~empty & dout_ready;
`ifdef RDECOUPLE_BYPASS_EN
        dout_valid = ~empty | push_in;
        dout_data  = empty ? din_data : mem[r_ptr];
        fifo_wr    = push_in & ~(empty & push_in & dout_ready);
`else
        dout_valid = ~empty;
        dout_data  = mem[r_ptr];
        fifo_wr    = push_in;
`endif
        count_next = count;
        if (fifo_wr & ~fifo_rd) begin
            count_next = count + 1'b1;
        end else if (~fifo_wr & fifo_rd) begin
            count_next = count - 1'b1;
        end
    end

    // din_ready looks one cycle ahead: a free slot now guarantees next cycle's push fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            w_ptr     <= '0;
            r_ptr     <= '0;
            din_ready <= 1'b0;
        end else begin
            count     <= count_next;
            din_ready <= (count_next < FULL);
            if (fifo_wr) begin
                w_ptr <= wrap_inc(w_ptr);
            end
            if (fifo_rd) begin
                r_ptr <= wrap_inc(r_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[w_ptr] <= din_data;
        end
    end

endmodule

// File: tb/tb_rdecouple.sv
// Randomized self-checking bench for rdecouple: DEPTH=2 and DEPTH=3 instances share stimulus
// and are compared every cycle against a queue-based model of the stream.
module tb_rdecouple;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din_data;
    logic        din_valid;
    logic        dout_ready;
    logic        rdy  [2];
    logic        vld  [2];
    logic [15:0] dat  [2];

    logic [15:0] mq   [2][$];
    logic        mrdy [2];
    logic        active = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rdecouple #(.DEPTH(2), .DIN(16)) u0 (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(rdy[0]),
        .dout_data(dat[0]), .dout_valid(vld[0]), .dout_ready(dout_ready)
    );

    rdecouple #(.DEPTH(3), .DIN(16)) u1 (
        .clk(clk), .rst(rst),
        .din_data(din_data), .din_valid(din_valid), .din_ready(rdy[1]),
        .dout_data(dat[1]), .dout_valid(vld[1]), .dout_ready(dout_ready)
    );

    function automatic int depth_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d, input logic dr);
        @(posedge clk);
        #1;
        rst        = r;
        din_valid  = v;
        din_data   = d;
        dout_ready = dr;
    endtask

    // Model: the words held between the two handshakes form a plain queue; din_ready mirrors
    // whether that queue had room after the previous cycle.
    always @(negedge clk) begin : compare
        int          sz;
        logic        push;
        logic        ev;
        logic [15:0] ed;
        if (active) begin
            for (int i = 0; i < 2; i++) begin
                sz   = mq[i].size();
                push = din_valid && mrdy[i];
`ifdef RDECOUPLE_BYPASS_EN
                ev = (sz > 0) || push;
                ed = (sz > 0) ? mq[i][0] : din_data;
`else
                ev = (sz > 0);
                ed = (sz > 0) ? mq[i][0] : 16'h0;
`endif
                checkOutput($sformatf("u%0d din_ready", i), {31'b0, rdy[i]}, {31'b0, mrdy[i]});
                checkOutput($sformatf("u%0d dout_valid", i), {31'b0, vld[i]}, {31'b0, ev});
                if (ev) begin
                    checkOutput($sformatf("u%0d dout_data", i), {16'b0, dat[i]}, {16'b0, ed});
                end
                if (rst) begin
                    mq[i].delete();
                    mrdy[i] = 1'b0;
                end else begin
`ifdef RDECOUPLE_BYPASS_EN
                    if (push) mq[i].push_back(din_data);
                    if (ev && dout_ready) void'(mq[i].pop_front());
`else
                    if (ev && dout_ready) void'(mq[i].pop_front());
                    if (push) mq[i].push_back(din_data);
`endif
                    checkOutput($sformatf("u%0d occupancy bound", i),
                                {31'b0, (mq[i].size() <= depth_of(i))}, 32'd1);
                    mrdy[i] = (mq[i].size() < depth_of(i));
                end
            end
        end
    end

    initial begin
        int pv;
        int pr;
        mrdy[0]    = 1'b0;
        mrdy[1]    = 1'b0;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_data   = 16'h0;
        dout_ready = 1'b0;

        // Reset held for three edges, then released.
        @(posedge clk);
        #1 active = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset din_ready", {31'b0, rdy[0]}, 32'd0);
        checkOutput("reset dout_valid", {31'b0, vld[0]}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset din_ready low", {31'b0, rdy[0]}, 32'd0);
        checkOutput("post-reset dout_valid", {31'b0, vld[1]}, 32'd0);

        // Stall: two words fill the DEPTH=2 skid, then drain in order.
        applyStimulus(1'b0, 1'b1, 16'h00A1, 1'b0);
        #1 checkOutput("ready after release", {31'b0, rdy[0]}, 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h00A2, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h00A3, 1'b0);
        #1;
        checkOutput("stall din_ready", {31'b0, rdy[0]}, 32'd0);
        checkOutput("stall dout_valid", {31'b0, vld[0]}, 32'd1);
        checkOutput("stall head", {16'b0, dat[0]}, 32'h00A1);
        applyStimulus(1'b0, 1'b1, 16'h00A3, 1'b1);
        #1 checkOutput("drain head A1", {16'b0, dat[0]}, 32'h00A1);
        applyStimulus(1'b0, 1'b1, 16'h00A3, 1'b1);
        #1;
        checkOutput("drain head A2", {16'b0, dat[0]}, 32'h00A2);
        checkOutput("push+pop ready", {31'b0, rdy[0]}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        #1;
        checkOutput("drain head A3", {16'b0, dat[0]}, 32'h00A3);
        checkOutput("count1 ready", {31'b0, rdy[0]}, 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0055, 1'b1);
        #1;
`ifdef RDECOUPLE_BYPASS_EN
        checkOutput("bypass valid", {31'b0, vld[0]}, 32'd1);
        checkOutput("bypass data", {16'b0, dat[0]}, 32'h0055);
`else
        checkOutput("no-bypass valid", {31'b0, vld[0]}, 32'd0);
`endif
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

        // Random traffic in blocks of differing valid/ready density, with occasional resets.
        for (int blk = 0; blk < 20; blk++) begin
            case (blk % 4)
                0: begin pv = 100; pr = 100; end
                1: begin pv = 100; pr = 30;  end
                2: begin pv = 40;  pr = 90;  end
                default: begin pv = $urandom_range(10, 100); pr = $urandom_range(10, 100); end
            endcase
            for (int c = 0; c < 150; c++) begin
                applyStimulus(($urandom_range(0, 79) == 0),
                              ($urandom_range(1, 100) <= pv),
                              16'($urandom()),
                              ($urandom_range(1, 100) <= pr));
            end
        end

        // Mid-stream reset with the buffers loaded.
        repeat (4) applyStimulus(1'b0, 1'b1, 16'($urandom()), 1'b0);
        applyStimulus(1'b1, 1'b1, 16'hDEAD, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0B01, 1'b1);
        #1;
        checkOutput("mid-reset dout_valid", {31'b0, vld[0]}, 32'd0);
        checkOutput("mid-reset din_ready", {31'b0, rdy[0]}, 32'd0);
        repeat (10) applyStimulus(1'b0, 1'b1, 16'($urandom()), 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
